data_mem_arbiter: RTL and testbench

//  Memory-stage data memory for the pipelined ARM core. Sits directly downstream of the datapath.

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/sync_ram_1p.sv | 30 +++
 rtl/data_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the memory-stage data memory arbiter.
package data_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } mem_state_t;

    // True when every byte-address bit above the word index is zero.
    function automatic logic cpu_addr_in_range(input logic [31:0] byte_addr, input int addr_w);
        return ((byte_addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/sync_ram_1p.sv
// Single-port synchronous RAM: write and read share one address, read-first,
// registered q one cycle after an enabled access. q holds while disabled.
module sync_ram_1p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_q;

    // Enabled access: optional write, and capture the old word onto q.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_q <= r_mem[i_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Memory-stage data memory: shares one single-port RAM between CPU
// loads/stores and the host image loader, stalling the pipeline on loads
// and whenever the host has been forced ahead of a CPU access.
//
// state   | meaning
// IDLE    | RAM free; CPU or host access may issue this cycle
// CPU_RD  | RAM q carries CPU load data; pipeline advances
// HOST_RD | RAM q carries host read data; CPU access waits
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we_m,
    input  logic              mem_re_m,
    input  logic [31:0]       alu_out_m,
    input  logic [WORD_W-1:0] write_data_m,
    output logic [WORD_W-1:0] read_data,
    output logic              mem_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [WORD_W-1:0] host_rdata
);

    localparam int                WAIT_W   = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

    mem_state_t        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WORD_W-1:0] r_read_hold;
    logic              r_cpu_oor;

    logic [ADDR_W-1:0] w_cpu_widx;
    logic              w_cpu_in_range;
    logic              w_cpu_acc;
    logic              w_idle;
    logic              w_force;
    logic              w_host_gnt;
    logic              w_cpu_store;
    logic              w_cpu_load;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_q;
    logic [WORD_W-1:0] w_cpu_rdata;
    logic              w_unused_byte_offset;

    // Byte offset is ignored: word accesses only.
    assign w_unused_byte_offset = ^alu_out_m[1:0];

    assign w_cpu_widx     = alu_out_m[ADDR_W+1:2];
    assign w_cpu_in_range = cpu_addr_in_range(alu_out_m, ADDR_W);
    assign w_cpu_acc      = mem_we_m | mem_re_m;
    assign w_idle         = (r_state == IDLE);
    assign w_force        = host_req && (r_wait_cnt == WAIT_MAX);

    // Issue decisions are only made in IDLE and never while reset is low,
    // so nothing touches the RAM at a reset edge.
    assign w_host_gnt  = reset && w_idle && host_req && (!w_cpu_acc || w_force);
    assign w_cpu_store = reset && w_idle && mem_we_m && !w_host_gnt;
    assign w_cpu_load  = reset && w_idle && mem_re_m && !mem_we_m && !w_host_gnt;

    assign w_ram_en    = w_host_gnt || w_cpu_load || (w_cpu_store && w_cpu_in_range);
    assign w_ram_we    = w_host_gnt ? host_we    : (w_cpu_store && w_cpu_in_range);
    assign w_ram_addr  = w_host_gnt ? host_addr  : w_cpu_widx;
    assign w_ram_wdata = w_host_gnt ? host_wdata : write_data_m;

    sync_ram_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    // Stall: load issue, host forced over a CPU access, or CPU blocked by a host read.
    always_comb begin
        mem_stall = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE:    mem_stall = w_cpu_load || (w_host_gnt && w_cpu_acc);
                HOST_RD: mem_stall = w_cpu_acc;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    assign w_cpu_rdata = r_cpu_oor ? '0 : w_ram_q;
    assign read_data   = (r_state == CPU_RD) ? w_cpu_rdata : r_read_hold;
    assign host_gnt    = w_host_gnt;
    assign host_rvalid = (r_state == HOST_RD);
    assign host_rdata  = host_rvalid ? w_ram_q : '0;

    // FSM, host wait counter and held CPU load data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_read_hold <= '0;
            r_cpu_oor   <= 1'b0;
        end else begin
            if (!host_req || w_host_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_host_gnt && !host_we) begin
                        r_state <= HOST_RD;
                    end else if (w_cpu_load) begin
                        r_state   <= CPU_RD;
                        r_cpu_oor <= !w_cpu_in_range;
                    end
                end
                CPU_RD: begin
                    r_read_hold <= w_cpu_rdata;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we_m;
    logic        mem_re_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W        (10),
        .HOST_MAX_WAIT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_we_m     (mem_we_m),
        .mem_re_m     (mem_re_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .read_data    (read_data),
        .mem_stall    (mem_stall),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cpu_idle();
        mem_we_m     = 1'b0;
        mem_re_m     = 1'b0;
        alu_out_m    = 32'h0;
        write_data_m = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_idle();
        mem_re_m  = 1'b1;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = '0;
        host_wdata = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            n_tests++;
            if (mem_stall !== 1'b0 || read_data !== 32'h0 || host_gnt !== 1'b0 || host_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: stall=%b rdata=%h gnt=%b rvalid=%b, required 0/0/0/0",
                         i, mem_stall, read_data, host_gnt, host_rvalid);
            end
        end
        tick();
        reset = 1'b1;
        cpu_idle();
    endtask

    task automatic test_store_load();
        tick();
        mem_we_m = 1'b1; alu_out_m = 32'h40; write_data_m = 32'hDEADBEEF;
        settle();
        n_tests++;
        if (mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL store_nostall: stall=%b required 0", mem_stall);
        end
        tick();
        mem_we_m = 1'b0; mem_re_m = 1'b1; alu_out_m = 32'h40;
        settle();
        n_tests++;
        if (mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL load_issue_stall: stall=%b required 1", mem_stall);
        end
        tick();
        settle();
        n_tests++;
        if (mem_stall !== 1'b0 || read_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_data: stall=%b rdata=%h required 0/deadbeef", mem_stall, read_data);
        end
        tick();
        cpu_idle();
        settle();
        n_tests++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_hold: rdata=%h required deadbeef", read_data);
        end
    endtask

    task automatic test_host_write();
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_wdata = 32'h12345678;
        settle();
        n_tests++;
        if (host_gnt !== 1'b1 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL host_wr_gnt: gnt=%b stall=%b required 1/0", host_gnt, mem_stall);
        end
        tick();
        host_req = 1'b0;
        mem_re_m = 1'b1; alu_out_m = 32'h14;
        settle();
        n_tests++;
        if (host_gnt !== 1'b0 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL host_wr_then_load: gnt=%b stall=%b required 0/1", host_gnt, mem_stall);
        end
        tick();
        settle();
        n_tests++;
        if (mem_stall !== 1'b0 || read_data !== 32'h12345678) begin
            n_fail++; $display("FAIL host_wr_readback: stall=%b rdata=%h required 0/12345678", mem_stall, read_data);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_forced_grant();
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'hA5A5_5A5A;
        mem_we_m = 1'b1; alu_out_m = 32'h80; write_data_m = 32'hC0FFEE00;
        settle();
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (host_gnt !== 1'b0 || mem_stall !== 1'b0) begin
                n_fail++; $display("FAIL force_wait[%0d]: gnt=%b stall=%b required 0/0", k, host_gnt, mem_stall);
            end
            tick();
            settle();
        end
        n_tests++;
        if (host_gnt !== 1'b1 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL force_gnt: gnt=%b stall=%b required 1/1", host_gnt, mem_stall);
        end
        tick();
        host_req = 1'b0;
        write_data_m = 32'hC0FFEE01;
        settle();
        n_tests++;
        if (host_gnt !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL force_retry_store: gnt=%b stall=%b required 0/0", host_gnt, mem_stall);
        end
        tick();
        mem_we_m = 1'b0; mem_re_m = 1'b1; alu_out_m = 32'h80;
        tick();
        settle();
        n_tests++;
        if (read_data !== 32'hC0FFEE01) begin
            n_fail++; $display("FAIL force_store_data: rdata=%h required c0ffee01", read_data);
        end
        tick();
        alu_out_m = 32'h1C;
        tick();
        settle();
        n_tests++;
        if (read_data !== 32'hA5A55A5A) begin
            n_fail++; $display("FAIL force_host_data: rdata=%h required a5a55a5a", read_data);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_host_read();
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
        settle();
        n_tests++;
        if (host_gnt !== 1'b1) begin
            n_fail++; $display("FAIL host_rd_gnt: gnt=%b required 1", host_gnt);
        end
        tick();
        host_req = 1'b0;
        mem_re_m = 1'b1; alu_out_m = 32'h40;
        settle();
        n_tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'h12345678 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL host_rd_data: rvalid=%b rdata=%h stall=%b required 1/12345678/1",
                               host_rvalid, host_rdata, mem_stall);
        end
        tick();
        settle();
        n_tests++;
        if (host_rvalid !== 1'b0 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL host_rd_stall2: rvalid=%b stall=%b required 0/1", host_rvalid, mem_stall);
        end
        tick();
        settle();
        n_tests++;
        if (mem_stall !== 1'b0 || read_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL host_rd_cpu_data: stall=%b rdata=%h required 0/deadbeef", mem_stall, read_data);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_out_of_range();
        tick();
        mem_we_m = 1'b1; alu_out_m = 32'h0; write_data_m = 32'hAAAA0000;
        tick();
        alu_out_m = 32'h0001_0000; write_data_m = 32'hBAD0BAD0;
        settle();
        n_tests++;
        if (mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL oor_store_stall: stall=%b required 0", mem_stall);
        end
        tick();
        mem_we_m = 1'b0; mem_re_m = 1'b1;
        settle();
        n_tests++;
        if (mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL oor_load_stall: stall=%b required 1", mem_stall);
        end
        tick();
        settle();
        n_tests++;
        if (mem_stall !== 1'b0 || read_data !== 32'h0) begin
            n_fail++; $display("FAIL oor_load_data: stall=%b rdata=%h required 0/0", mem_stall, read_data);
        end
        tick();
        alu_out_m = 32'h0;
        tick();
        settle();
        n_tests++;
        if (read_data !== 32'hAAAA0000) begin
            n_fail++; $display("FAIL oor_ram0_intact: rdata=%h required aaaa0000", read_data);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_reset_abort();
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
        reset = 1'b0;
        settle();
        n_tests++;
        if (host_gnt !== 1'b0) begin
            n_fail++; $display("FAIL abort_gnt_in_reset: gnt=%b required 0", host_gnt);
        end
        tick();
        reset = 1'b1; host_req = 1'b0;
        settle();
        n_tests++;
        if (host_rvalid !== 1'b0 || read_data !== 32'h0) begin
            n_fail++; $display("FAIL abort_after_reset: rvalid=%b rdata=%h required 0/0", host_rvalid, read_data);
        end
        tick();
        settle();
        n_tests++;
        if (host_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL abort_late_rvalid: rvalid=%b required 0", host_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_host_write();
        test_forced_grant();
        test_host_read();
        test_out_of_range();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
